pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 42 ++++
 rtl/pipe_load_use_det.sv | 14 +
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: register-number width,
// controller states and the bundle of pipeline-register controls.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W     = 5;
  localparam int unsigned STATE_W   = 2;
  localparam int unsigned MUL_CNT_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MUL_BUSY = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                    exmem_en: 1'b1, memwb_en: 1'b1, ifid_flush: 1'b0,
                                    idex_flush: 1'b0, exmem_bubble: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0,
                                    exmem_en: 1'b0, memwb_en: 1'b0, ifid_flush: 1'b0,
                                    idex_flush: 1'b0, exmem_bubble: 1'b0};
  localparam ctrl_t CTRL_MUL    = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0,
                                    exmem_en: 1'b1, memwb_en: 1'b1, ifid_flush: 1'b0,
                                    idex_flush: 1'b0, exmem_bubble: 1'b1};
  localparam ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                    exmem_en: 1'b1, memwb_en: 1'b1, ifid_flush: 1'b1,
                                    idex_flush: 1'b1, exmem_bubble: 1'b0};
  localparam ctrl_t CTRL_LD_USE = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b1,
                                    exmem_en: 1'b1, memwb_en: 1'b1, ifid_flush: 1'b0,
                                    idex_flush: 1'b1, exmem_bubble: 1'b0};

endpackage

// File: rtl/pipe_load_use_det.sv
// Load-use hazard detect: a load in EX writes a nonzero register read by ID.
module pipe_load_use_det
  import pipe_ctrl_pkg::*;
(
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_wn,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             load_use_c
);

  assign load_use_c = ex_mem_read && (ex_wn != '0) && ((ex_wn == id_rs) || (ex_wn == id_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller for memory waits, multi-cycle multiply, taken
// branches and load-use hazards. Define PIPE_STALL_CNT_EN to add the stall_cycles counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic [REG_W-1:0]   ex_wn,
  input  logic               ex_mem_read,
  input  logic               ex_mul_start,
  input  logic               branch_taken,
  input  logic               mem_req,
  input  logic               dmem_ready,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               idex_en,
  output logic               exmem_en,
  output logic               memwb_en,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic               exmem_bubble,
  output logic [STATE_W-1:0] state
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);

  typedef enum logic [2:0] {
    ACT_RST, ACT_MEM, ACT_MUL_START, ACT_MUL_HOLD, ACT_BRANCH, ACT_LD_USE, ACT_NORMAL
  } act_e;

  state_e                 state_q;
  logic [MUL_CNT_W-1:0]   mul_cnt_q;
  logic                   load_use;
  logic                   mem_stall;
  act_e                   act;
  ctrl_t                  ctrl;

  pipe_load_use_det u_load_use_det (
    .ex_mem_read (ex_mem_read),
    .ex_wn       (ex_wn),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .load_use_c  (load_use)
  );

  assign mem_stall = mem_req && !dmem_ready;

  // Resolve this cycle's action by priority; MEM_WAIT once ready, an expired
  // multiply and the unused encoding all fall through to RUN behaviour.
  always_comb begin
    act = ACT_NORMAL;
    if (rst)                                               act = ACT_RST;
    else if (mem_stall)                                    act = ACT_MEM;
    else if ((state_q == ST_MUL_BUSY) && (mul_cnt_q != '0)) act = ACT_MUL_HOLD;
    else if (ex_mul_start)                                 act = ACT_MUL_START;
    else if (branch_taken)                                 act = ACT_BRANCH;
    else if (load_use)                                     act = ACT_LD_USE;
  end

  always_comb begin
    ctrl = CTRL_NORMAL;
    case (act)
      ACT_MEM:                     ctrl = CTRL_FREEZE;
      ACT_MUL_START, ACT_MUL_HOLD: ctrl = CTRL_MUL;
      ACT_BRANCH:                  ctrl = CTRL_BRANCH;
      ACT_LD_USE:                  ctrl = CTRL_LD_USE;
      default:                     ctrl = CTRL_NORMAL;
    endcase
  end

  // A memory stall during a multiply freezes state and count so the stall resumes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      mul_cnt_q <= '0;
    end else begin
      case (act)
        ACT_MEM: begin
          if (state_q != ST_MUL_BUSY) state_q <= ST_MEM_WAIT;
        end
        ACT_MUL_START: begin
          state_q   <= ST_MUL_BUSY;
          mul_cnt_q <= MUL_CNT_W'(MUL_LAT - 1);
        end
        ACT_MUL_HOLD: begin
          mul_cnt_q <= mul_cnt_q - MUL_CNT_W'(1);
        end
        default: begin
          state_q   <= ST_RUN;
          mul_cnt_q <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                  stall_cycles <= '0;
    else if (!ctrl.pc_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

  assign pc_en        = ctrl.pc_en;
  assign ifid_en      = ctrl.ifid_en;
  assign idex_en      = ctrl.idex_en;
  assign exmem_en     = ctrl.exmem_en;
  assign memwb_en     = ctrl.memwb_en;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_flush   = ctrl.idex_flush;
  assign exmem_bubble = ctrl.exmem_bubble;
  assign state        = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a cycle-level model of the stall rules
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MUL_LAT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_wn = '0;
  logic       ex_mem_read = 1'b0, ex_mul_start = 1'b0, branch_taken = 1'b0;
  logic       mem_req = 1'b0, dmem_ready = 1'b1;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_bubble;
  logic [1:0] state;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_wn        (ex_wn),
    .ex_mem_read  (ex_mem_read),
    .ex_mul_start (ex_mul_start),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .dmem_ready   (dmem_ready),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_bubble (exmem_bubble),
    .state        (state)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Model: a multiply owes MUL_LAT stall cycles counted up from its start cycle;
  // once all are served it spends one more cycle in MUL_BUSY letting it advance.
  bit          m_mul_active = 1'b0;
  int          m_mul_served = 0;
  bit          m_mem_wait   = 1'b0;
  logic [31:0] m_stall      = '0;

  function automatic logic [7:0] model_ctrl();
    if (rst)                                      return 8'hF8;
    if (mem_req && !dmem_ready)                   return 8'h00;
    if (m_mul_active && m_mul_served < MUL_LAT)   return 8'h19;
    if (ex_mul_start)                             return 8'h19;
    if (branch_taken)                             return 8'hFE;
    if (ex_mem_read && ex_wn != 5'd0 && (ex_wn == id_rs || ex_wn == id_rt)) return 8'h3A;
    return 8'hF8;
  endfunction

  function automatic logic [1:0] model_state();
    if (m_mul_active) return 2'd2;
    if (m_mem_wait)   return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [7:0] dut_ctrl();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_bubble};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [7:0] e;
    e = model_ctrl();
    if (rst) begin
      m_mul_active = 1'b0;
      m_mul_served = 0;
      m_mem_wait   = 1'b0;
      m_stall      = '0;
    end else begin
      if (!e[7] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (mem_req && !dmem_ready) begin
        if (!m_mul_active) m_mem_wait = 1'b1;
      end else begin
        m_mem_wait = 1'b0;
        if (m_mul_active && m_mul_served < MUL_LAT) m_mul_served++;
        else if (ex_mul_start) begin
          m_mul_active = 1'b1;
          m_mul_served = 1;
        end else m_mul_active = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_ctrl", 32'(dut_ctrl()), 32'(model_ctrl()));
    check("cyc_state", 32'(state), 32'(model_state()));
`ifdef PIPE_STALL_CNT_EN
    check("cyc_stall_cnt", stall_cycles, m_stall);
`endif
  end

  // Apply one cycle of inputs just after the rising edge; return at the falling edge.
  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] wn, input logic mr, input logic ms,
                      input logic bt, input logic mq, input logic dr);
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rt = rt; ex_wn = wn;
    ex_mem_read = mr; ex_mul_start = ms; branch_taken = bt;
    mem_req = mq; dmem_ready = dr;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [7:0] exp_ctrl, input logic [1:0] exp_state);
    check({name, "_ctrl"}, 32'(dut_ctrl()), 32'(exp_ctrl));
    check({name, "_state"}, 32'(state), 32'(exp_state));
    check({name, "_model"}, 32'(model_ctrl()), 32'(exp_ctrl));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);  lit("reset", 8'hF8, 2'd0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);  lit("reset_over_mem", 8'hF8, 2'd0);

    step(0, 3, 8, 8, 1, 0, 0, 0, 1);  lit("lu_rt", 8'h3A, 2'd0);
    step(0, 3, 8, 0, 0, 0, 0, 0, 1);  lit("lu_next", 8'hF8, 2'd0);
    step(0, 8, 0, 8, 1, 0, 0, 0, 1);  lit("lu_rs", 8'h3A, 2'd0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 1);  lit("lu_r0", 8'hF8, 2'd0);
    step(0, 3, 8, 8, 1, 0, 1, 0, 1);  lit("branch_over_lu", 8'hFE, 2'd0);

    step(0, 0, 0, 0, 0, 1, 0, 0, 1);  lit("mul_t0", 8'h19, 2'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);  lit("mul_t1", 8'h19, 2'd2);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);  lit("mul_t2_branch", 8'h19, 2'd2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);  lit("mul_t3", 8'h19, 2'd2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);  lit("mul_t4", 8'hF8, 2'd2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);  lit("mul_t5", 8'hF8, 2'd0);

    step(0, 0, 0, 0, 0, 0, 0, 1, 0);  lit("mem_w0", 8'h00, 2'd0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);  lit("mem_w1", 8'h00, 2'd1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);  lit("mem_w2", 8'h00, 2'd1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);  lit("mem_ready", 8'hF8, 2'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);  lit("mem_done", 8'hF8, 2'd0);

    step(0, 0, 0, 0, 0, 0, 0, 1, 0);  lit("memb_w", 8'h00, 2'd0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);  lit("memb_branch", 8'hFE, 2'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);  lit("memb_done", 8'hF8, 2'd0);

    // Multiply with a two-cycle memory stall landing at mul_cnt=2.
    n = 0;
    step(0, 0, 0, 0, 0, 1, 0, 0, 1);  if (!pc_en) n++;
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);  if (!pc_en) n++;
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);  lit("mulmem_s0", 8'h00, 2'd2);  if (!pc_en) n++;
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);  lit("mulmem_s1", 8'h00, 2'd2);  if (!pc_en) n++;
    k = 0;
    do begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      if (!pc_en) n++;
      k++;
    end while (!pc_en && k < 20);
    check("mulmem_stall_len", 32'(n), 32'd6);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);  lit("mulmem_done", 8'hF8, 2'd0);

    // Reset in the middle of a multiply abandons it.
    step(0, 0, 0, 0, 0, 1, 0, 0, 1);  lit("rstmul_t0", 8'h19, 2'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);  lit("rstmul_t1", 8'h19, 2'd2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);  lit("rstmul_rst", 8'hF8, 2'd2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);  lit("rstmul_after", 8'hF8, 2'd0);
`ifdef PIPE_STALL_CNT_EN
    check("rstmul_stall_cnt", stall_cycles, 32'd0);
`endif
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);  lit("rstmul_run", 8'hF8, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
